button_cmd_encoder: RTL
=======================

Name: button_cmd_encoder

Overview:
- Input-side front end for the 8-bit calculator datapath. This is the counterpart to the display path: the display path serialises results out to the 7-segment digits, and this block collects operator commands in.
- It synchronises and debounces the six raw pushbuttons and turns each clean press into a single encoded command.
- Each command carries a snapshot of the A/B switch operands and is presented on a valid/ready handshake to the control unit.
- It replaces level-sampled button handling with one event per physical press.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).
- CNT_W, 20: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 50000000: auto-repeat period while a button is held. Used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- addition, subtraction, multiplication, divide, previous, write_enable  in  1 each  raw pushbuttons, asynchronous, bouncy
- A  in  8  operand A switches, asynchronous
- B  in  8  operand B switches, asynchronous
- cmd_opcode  out  3  encoded command
- cmd_a  out  8  A snapshot taken with the command
- cmd_b  out  8  B snapshot taken with the command
- cmd_valid  out  1  command pending
- cmd_ready  in  1  consumer accepts the command this cycle
- cmd_drop  out  1  sticky flag: a press was lost because the command slot was full

Behaviour:
- Reset (reset=0) immediately clears all outputs and all internal state: cmd_opcode=0, cmd_a=0, cmd_b=0, cmd_valid=0, cmd_drop=0, all synchronisers=0, all debounced levels=0, all counters=0.
- Synchronisers:
  - Every button, and every bit of A and B, passes through a 2-FF synchroniser.
  - A and B are not debounced.
- Debounce (per button, independent):
  - A counter increments each cycle that the synchronised level differs from the debounced level.
  - It clears to 0 on any cycle where the two levels agree. Bounce shorter than DEBOUNCE_CYCLES therefore produces nothing.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips on the next edge and the counter clears.
- Press event: generated on the cycle the debounced level flips 0->1.
  - Releases (1->0) produce no event.
  - Holding a button produces exactly one event.
- Encoding: addition=3'b001, subtraction=3'b010, multiplication=3'b011, divide=3'b100, previous=3'b101, write_enable=3'b110. The value 3'b000 is never issued.
- Simultaneous events in the same cycle:
  - Fixed priority: addition > subtraction > multiplication > divide > previous > write_enable.
  - The winner is loaded; each loser is treated as a drop (sets cmd_drop).
- Command slot (single entry):
  - An event loads cmd_opcode, cmd_a and cmd_b (from synchronised A/B in that cycle) and sets cmd_valid=1 when either cmd_valid=0, or cmd_valid=1 and cmd_ready=1 in the same cycle (back-to-back accept+load).
  - Event while cmd_valid=1 and cmd_ready=0: the event is discarded, the slot is unchanged, and cmd_drop is set to 1.
  - cmd_drop stays set until reset.
  - cmd_ready=1 with no event and cmd_valid=1: cmd_valid clears next edge. cmd_opcode, cmd_a and cmd_b hold their last values.
  - While cmd_valid=1, cmd_opcode, cmd_a and cmd_b are stable and do not change until accepted.
- Latency: a raw button held high from cycle 0 gives cmd_valid=1 after exactly DEBOUNCE_CYCLES+3 rising edges (2 sync + DEBOUNCE_CYCLES debounce + 1 load).
- Reset mid-press: the debounced level restarts at 0. A button still held after reset deasserts yields one event DEBOUNCE_CYCLES+3 edges after deassertion.

Optional Feature:
- Macro: AUTO_REPEAT_EN
- Defined:
  - While a button's debounced level stays 1, a per-block repeat counter (shared, tracking the highest-priority held button) emits an additional press event for that button every REPEAT_CYCLES cycles after the initial event.
  - The counter clears on release or on a change of the held winner.
  - Repeat events follow the same slot and drop rules.
- Undefined: no repeat counter is built and REPEAT_CYCLES is ignored; holding a button produces exactly one event.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20):
1. Clean press: hold subtraction high with A=8'h2A, B=8'h05 and cmd_ready=0. Required: cmd_valid rises after exactly 7 edges with cmd_opcode=3'b010, cmd_a=8'h2A, cmd_b=8'h05, and holds until cmd_ready=1; cmd_valid then clears next edge.
2. Bounce rejection: toggle divide 1,0,1,0 at 2-cycle intervals, then leave it 0. Required: no cmd_valid, cmd_drop=0. Then hold divide high 10 cycles: exactly one command with 3'b100.
3. Priority/drop: addition and write_enable rise on the same cycle. Required: cmd_opcode=3'b001 and cmd_drop=1.
4. Full slot: with cmd_valid=1 (multiplication pending) and cmd_ready=0, press previous. Required: the slot still holds 3'b011 and cmd_drop=1. With cmd_ready=1 held and a previous press arriving on the accept cycle, cmd_valid stays 1 and cmd_opcode becomes 3'b101 the next edge.
5. Async reset: pull reset low mid-debounce with cmd_valid=1. Required: all outputs are 0 immediately, before the next clk edge. A button held through reset gives a command 7 edges after release of reset.
6. AUTO_REPEAT_EN defined: hold addition for 70 cycles with cmd_ready=1. Required: events at edge 7, then every 20 edges (27, 47, 67), each with 3'b001. Without the macro: only the edge-7 event.

Source files
------------

// File: rtl/button_cmd_encoder.sv
// button_cmd_encoder: synchronises and debounces six pushbuttons and turns each
// clean press into one encoded command. Each command carries a snapshot of the
// A/B operands and sits in a single-entry valid/ready slot.
// Optional build macro AUTO_REPEAT_EN: a held button re-issues its command every
// REPEAT_CYCLES cycles (highest-priority held button only).
module button_cmd_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       addition,
  input  logic       subtraction,
  input  logic       multiplication,
  input  logic       divide,
  input  logic       previous,
  input  logic       write_enable,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [2:0] cmd_opcode,
  output logic [7:0] cmd_a,
  output logic [7:0] cmd_b,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_drop
);

  localparam int unsigned NBTN   = 6;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order is priority order: bit 0 (addition) wins.
  logic [NBTN-1:0] btn_raw;
  assign btn_raw = {write_enable, previous, divide, multiplication, subtraction, addition};

  logic [NBTN-1:0]   btn_s1_q, btn_s2_q;
  logic [DATA_W-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;

  logic [CNT_W-1:0]  cnt_q [NBTN];
  logic [CNT_W-1:0]  cnt_d [NBTN];
  logic [NBTN-1:0]   deb_q, deb_d, deb_prev_q;

  logic [NBTN-1:0]   press;
  logic [NBTN-1:0]   ev;
  logic [NBTN-1:0]   ev_win;
  logic              ev_lose;
  logic [OP_W-1:0]   ev_op;

  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              valid_q, valid_d;
  logic              drop_q, drop_d;

  // Two-flop synchronisers for buttons and operand switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      a_s1_q   <= '0;
      a_s2_q   <= '0;
      b_s1_q   <= '0;
      b_s2_q   <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      a_s1_q   <= A;
      a_s2_q   <= a_s1_q;
      b_s1_q   <= B;
      b_s2_q   <= b_s1_q;
    end
  end

  // Per-button debounce: count cycles of disagreement, flip after DEBOUNCE_CYCLES.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and previous level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  assign press = deb_q & ~deb_prev_q;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [NBTN-1:0]  held_win, win_q;
  logic             rpt_fire;

  // Highest-priority held button, one-hot.
  assign held_win = deb_q & (~deb_q + NBTN'(1));

  // Repeat timer: restarts whenever the held winner changes or is released.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if ((held_win != '0) && (held_win == win_q)) begin
      if (rpt_q == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q <= '0;
      win_q <= '0;
    end else begin
      rpt_q <= rpt_d;
      win_q <= held_win;
    end
  end

  assign ev = press | (rpt_fire ? held_win : '0);
`else
  assign ev = press;
`endif

  // Priority pick among simultaneous events.
  always_comb begin
    ev_win  = ev & (~ev + NBTN'(1));
    ev_lose = (ev & ~ev_win) != '0;
    ev_op   = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (ev_win[i]) ev_op = OP_W'(i + 1);
    end
  end

  // Single-entry command slot with sticky drop flag.
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    if (ev != '0) begin
      if (ev_lose) drop_d = 1'b1;
      if (!valid_q || cmd_ready) begin
        op_d    = ev_op;
        a_d     = a_s2_q;
        b_d     = b_s2_q;
        valid_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (valid_q && cmd_ready) begin
      valid_d = 1'b0;
    end
  end

  // Command slot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign cmd_opcode = op_q;
  assign cmd_a      = a_q;
  assign cmd_b      = b_q;
  assign cmd_valid  = valid_q;
  assign cmd_drop   = drop_q;

endmodule
